// File: rtl/rns_reverse_converter.sv
// rns_reverse_converter: sequential RNS residue-to-binary decoder using an incremental residue counter search
// Optional early abort on non-coprime moduli when RNS_COPRIME_CHECK_EN is defined.
module rns_reverse_converter #(
    parameter int RES_W = 3,
    parameter int OUT_W = 3 * RES_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [RES_W-1:0] res1_i,
    input  logic [RES_W-1:0] res2_i,
    input  logic [RES_W-1:0] res3_i,
    input  logic [RES_W-1:0] moduli1_i,
    input  logic [RES_W-1:0] moduli2_i,
    input  logic [RES_W-1:0] moduli3_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] bin_out_o,
    output logic             err_o
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t           state_q;
    logic [RES_W-1:0] r_q [3];
    logic [RES_W-1:0] m_q [3];
    logic [RES_W-1:0] c_q [3];
    logic [RES_W-1:0] c_d [3];
    logic [RES_W-1:0] r_in [3];
    logic [RES_W-1:0] m_in [3];
    logic [OUT_W-1:0] x_q, x_d, mm_q, mm_d;
    logic [OUT_W-1:0] bin_q;
    logic             in_ready_q, out_valid_q, err_q;
    logic             bad_in, match, last, wrap;

    assign r_in = '{res1_i, res2_i, res3_i};
    assign m_in = '{moduli1_i, moduli2_i, moduli3_i};
    assign mm_d = OUT_W'(moduli1_i) * OUT_W'(moduli2_i) * OUT_W'(moduli3_i);
    assign x_d  = x_q + OUT_W'(1);
    assign last = (x_q == mm_q - OUT_W'(1));

    // Input legality, per-channel counter step and current-match detection
    always_comb begin
        bad_in = 1'b0;
        match  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bad_in = bad_in | (m_in[i] < RES_W'(2)) | (r_in[i] >= m_in[i]);
            match  = match & (c_q[i] == r_q[i]);
            c_d[i] = (c_q[i] == m_q[i] - RES_W'(1)) ? '0 : c_q[i] + RES_W'(1);
        end
    end

`ifdef RNS_COPRIME_CHECK_EN
    // Every counter about to roll over together means the tuple returns to (0,0,0) next step,
    // i.e. it has cycled at lcm < M without a match: abort instead of walking up to M
    always_comb begin
        wrap = 1'b1;
        for (int i = 0; i < 3; i++) wrap = wrap & (c_q[i] == m_q[i] - RES_W'(1));
    end
`else
    assign wrap = 1'b0;
`endif

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            bin_q       <= '0;
            err_q       <= 1'b0;
            x_q         <= '0;
            mm_q        <= '0;
            for (int i = 0; i < 3; i++) begin
                c_q[i] <= '0;
                r_q[i] <= '0;
                m_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        x_q        <= '0;
                        mm_q       <= mm_d;
                        for (int i = 0; i < 3; i++) begin
                            c_q[i] <= '0;
                            r_q[i] <= r_in[i];
                            m_q[i] <= m_in[i];
                        end
                        if (bad_in) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            bin_q       <= '0;
                            err_q       <= 1'b1;
                        end else begin
                            state_q <= SEARCH;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                SEARCH: begin
                    if (match || last || wrap) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        bin_q       <= match ? x_q : '0;
                        err_q       <= !match;
                    end else begin
                        x_q <= x_d;
                        c_q <= c_d;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign bin_out_o   = bin_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_rns_reverse_converter.sv
// tb_rns_reverse_converter: table, random and corner-sequence checks of rns_reverse_converter
module tb_rns_reverse_converter;
    localparam int RES_W = 3;
    localparam int OUT_W = 9;
`ifdef RNS_COPRIME_CHECK_EN
    localparam int NOSOL_LAT = 12;
`else
    localparam int NOSOL_LAT = 24;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             err;
    logic [RES_W-1:0] res1 = '0, res2 = '0, res3 = '0;
    logic [RES_W-1:0] mod1 = '0, mod2 = '0, mod3 = '0;
    logic [OUT_W-1:0] bin_out;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rns_reverse_converter #(.RES_W(RES_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .res1_i(res1), .res2_i(res2), .res3_i(res3),
        .moduli1_i(mod1), .moduli2_i(mod2), .moduli3_i(mod3),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .bin_out_o(bin_out), .err_o(err)
    );

    typedef struct {
        int m1, m2, m3, r1, r2, r3;
        int bin, err, lat;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: brute-force first x in [0,M) matching all residues; latency from the search rules
    function automatic void model(input int m1, m2, m3, r1, r2, r3, output int bin, output int e, output int lat);
        int mm, l;
        bin = 0;
        e = 1;
        lat = 0;
        if (m1 < 2 || m2 < 2 || m3 < 2 || r1 >= m1 || r2 >= m2 || r3 >= m3) return;
        mm = m1 * m2 * m3;
        l = mm;
        for (int x = 1; x <= mm; x++)
            if (x % m1 == 0 && x % m2 == 0 && x % m3 == 0) begin
                l = x;
                break;
            end
        for (int x = 0; x < mm; x++)
            if (x % m1 == r1 && x % m2 == r2 && x % m3 == r3) begin
                bin = x;
                e = 0;
                lat = x + 1;
                return;
            end
`ifdef RNS_COPRIME_CHECK_EN
        lat = l;
`else
        lat = mm;
`endif
    endfunction

    task automatic convert(input int m1, m2, m3, r1, r2, r3, output int bin, output int e, output int lat);
        int w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("in_ready_wait", 0, 1);
        mod1 = RES_W'(m1); mod2 = RES_W'(m2); mod3 = RES_W'(m3);
        res1 = RES_W'(r1); res2 = RES_W'(r2); res3 = RES_W'(r3);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        bin = int'(bin_out);
        e = int'(err);
    endtask

    task automatic run_check(input string tag, input int m1, m2, m3, r1, r2, r3, eb, ee, el);
        int b, e, l;
        convert(m1, m2, m3, r1, r2, r3, b, e, l);
        chk($sformatf("%s_bin(%0d,%0d,%0d|%0d,%0d,%0d)", tag, m1, m2, m3, r1, r2, r3), b, eb);
        chk($sformatf("%s_err", tag), e, ee);
        chk($sformatf("%s_lat", tag), l, el);
        @(negedge clk);
        chk($sformatf("%s_post_valid", tag), int'(out_valid), 0);
        chk($sformatf("%s_post_ready", tag), int'(in_ready), 1);
    endtask

    initial begin
        int m[3], r[3], eb, ee, el, b, e, l;
        tbl[0] = '{3, 5, 7, 1, 2, 3, 52, 0, 53};
        tbl[1] = '{3, 5, 7, 0, 0, 0, 0, 0, 1};
        tbl[2] = '{3, 5, 7, 2, 4, 6, 104, 0, 105};
        tbl[3] = '{3, 5, 7, 1, 5, 0, 0, 1, 0};
        tbl[4] = '{1, 5, 7, 0, 0, 0, 0, 1, 0};
        tbl[5] = '{3, 5, 1, 0, 0, 0, 0, 1, 0};
        tbl[6] = '{2, 4, 3, 1, 2, 0, 0, 1, NOSOL_LAT};
        tbl[7] = '{7, 2, 3, 6, 1, 2, 41, 0, 42};

        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_bin", int'(bin_out), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 8; i++)
            run_check($sformatf("tbl%0d", i), tbl[i].m1, tbl[i].m2, tbl[i].m3,
                      tbl[i].r1, tbl[i].r2, tbl[i].r3, tbl[i].bin, tbl[i].err, tbl[i].lat);

        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 3; i++) begin
                m[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(2, 7));
                r[i] = ($urandom_range(0, 7) == 0 || m[i] < 2) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, m[i] - 1));
            end
            model(m[0], m[1], m[2], r[0], r[1], r[2], eb, ee, el);
            run_check($sformatf("rnd%0d", k), m[0], m[1], m[2], r[0], r[1], r[2], eb, ee, el);
        end

        out_ready = 1'b0;
        convert(3, 5, 7, 1, 2, 3, b, e, l);
        chk("bp_bin", b, 52);
        chk("bp_lat", l, 53);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_bin", int'(bin_out), 52);
            chk("bp_hold_err", int'(err), 0);
            chk("bp_hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_in_ready", int'(in_ready), 1);

        mod1 = 3'd3; mod2 = 3'd5; mod3 = 3'd7;
        res1 = 3'd1; res2 = 3'd2; res3 = 3'd3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_still_searching", int'(out_valid), 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_bin", int'(bin_out), 0);
        chk("mid_rst_err", int'(err), 0);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("mid_rst_no_result", int'(out_valid), 0);
        run_check("after_rst", 3, 5, 7, 1, 2, 3, 52, 0, 53);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
